// File: rtl/monitor_conditions.sv
// Environmental condition monitor: registers per-channel out-of-range flags and
// filters them into a debounced alert with a saturating rising-edge counter.
module monitor_conditions #(
  parameter logic [7:0]  TEMP_MIN = 8'd5,
  parameter logic [7:0]  TEMP_MAX = 8'd45,
  parameter logic [7:0]  HUM_MAX  = 8'd85,
  parameter logic [15:0] PRES_MIN = 16'd950,
  parameter logic [15:0] PRES_MAX = 16'd1050,
  parameter int unsigned CONFIRM  = 3,
  parameter int unsigned CLEAR    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  temp,
  input  logic [7:0]  hum,
  input  logic [15:0] pres,
  output logic        alert,
  output logic        temp_fault,
  output logic        hum_fault,
  output logic        pres_fault,
  output logic [7:0]  alert_events
);

  // Reject nonsensical configurations at elaboration time.
  if (TEMP_MIN > TEMP_MAX) begin : gen_bad_temp
    $error("monitor_conditions: TEMP_MIN must not exceed TEMP_MAX");
  end
  if (PRES_MIN > PRES_MAX) begin : gen_bad_pres
    $error("monitor_conditions: PRES_MIN must not exceed PRES_MAX");
  end
  if (CONFIRM < 1 || CONFIRM > 15) begin : gen_bad_confirm
    $error("monitor_conditions: CONFIRM must be within 1..15");
  end
  if (CLEAR < 1 || CLEAR > 15) begin : gen_bad_clear
    $error("monitor_conditions: CLEAR must be within 1..15");
  end

  localparam logic [3:0] ConfirmLast = 4'(CONFIRM - 1);
  localparam logic [3:0] ClearLast   = 4'(CLEAR - 1);

  logic       temp_bad, hum_bad, pres_bad, any_bad;
  logic       temp_fault_q, hum_fault_q, pres_fault_q;
  logic       alert_d, alert_q;
  logic [3:0] cnt_d, cnt_q;
  logic [7:0] events_d, events_q;

  // Strict range checks; threshold-equal samples count as in range.
  always_comb begin
    temp_bad = (temp < TEMP_MIN) || (temp > TEMP_MAX);
    hum_bad  = (hum > HUM_MAX);
    pres_bad = (pres < PRES_MIN) || (pres > PRES_MAX);
    any_bad  = temp_fault_q || hum_fault_q || pres_fault_q;
  end

  // Persistence filter: count consecutive cycles that disagree with alert.
  always_comb begin
    alert_d  = alert_q;
    cnt_d    = 4'd0;
    events_d = events_q;
    if (!alert_q) begin
      if (any_bad) begin
        if (cnt_q == ConfirmLast) begin
          alert_d = 1'b1;
          if (events_q != 8'hFF) begin
            events_d = events_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end else begin
      if (!any_bad) begin
        if (cnt_q == ClearLast) begin
          alert_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end
  end

  // State registers; reset discards all filter progress immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_fault_q <= 1'b0;
      hum_fault_q  <= 1'b0;
      pres_fault_q <= 1'b0;
      alert_q      <= 1'b0;
      cnt_q        <= 4'd0;
      events_q     <= 8'd0;
    end else begin
      temp_fault_q <= temp_bad;
      hum_fault_q  <= hum_bad;
      pres_fault_q <= pres_bad;
      alert_q      <= alert_d;
      cnt_q        <= cnt_d;
      events_q     <= events_d;
    end
  end

  assign alert        = alert_q;
  assign temp_fault   = temp_fault_q;
  assign hum_fault    = hum_fault_q;
  assign pres_fault   = pres_fault_q;
  assign alert_events = events_q;

endmodule

// File: tb/tb_monitor_conditions.sv
// Bench for monitor_conditions: a driver issues one sample per cycle and pushes
// the reference model's expected outputs; a monitor pops and compares them.
module tb_monitor_conditions;

  localparam int TMin = 5, TMax = 45, HMax = 85, PMin = 950, PMax = 1050;
  localparam int Confirm = 3, Clear = 3;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  temp = 8'd200;
  logic [7:0]  hum = 8'd0;
  logic [15:0] pres = 16'd1000;
  logic        alert, temp_fault, hum_fault, pres_fault;
  logic [7:0]  alert_events;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       alert;
    logic       tf;
    logic       hf;
    logic       pf;
    logic [7:0] ev;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  bit m_tf, m_hf, m_pf, m_alert;
  int m_run, m_events;

  monitor_conditions #(
    .TEMP_MIN(8'(TMin)), .TEMP_MAX(8'(TMax)), .HUM_MAX(8'(HMax)),
    .PRES_MIN(16'(PMin)), .PRES_MAX(16'(PMax)), .CONFIRM(Confirm), .CLEAR(Clear)
  ) dut (
    .clk(clk), .rst_n(rst_n), .temp(temp), .hum(hum), .pres(pres),
    .alert(alert), .temp_fault(temp_fault), .hum_fault(hum_fault),
    .pres_fault(pres_fault), .alert_events(alert_events)
  );

  always #5 clk = clk_en ? ~clk : clk;

  function automatic void model_reset();
    m_tf = 0; m_hf = 0; m_pf = 0; m_alert = 0; m_run = 0; m_events = 0;
  endfunction

  // One clock edge of the model: the alert toggles once the flags have
  // disagreed with it for the required number of consecutive edges.
  function automatic void model_step(int t, int h, int p);
    bit any_bad;
    int need;
    any_bad = m_tf || m_hf || m_pf;
    if (any_bad != m_alert) m_run++;
    else m_run = 0;
    need = m_alert ? Clear : Confirm;
    if (m_run == need) begin
      m_alert = !m_alert;
      m_run = 0;
      if (m_alert && m_events < 255) m_events++;
    end
    m_tf = (t < TMin) || (t > TMax);
    m_hf = (h > HMax);
    m_pf = (p < PMin) || (p > PMax);
  endfunction

  // Called at a falling edge: apply a sample, predict, advance one cycle.
  task automatic cycle(int t, int h, int p);
    exp_t e;
    temp = 8'(t); hum = 8'(h); pres = 16'(p);
    model_step(t, h, p);
    e.alert = m_alert; e.tf = m_tf; e.hf = m_hf; e.pf = m_pf; e.ev = 8'(m_events);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_zero(string name);
    n_tests++;
    if (alert !== 1'b0 || temp_fault !== 1'b0 || hum_fault !== 1'b0 ||
        pres_fault !== 1'b0 || alert_events !== 8'd0) begin
      n_fail++;
      $display("FAIL %s: got alert=%b tf=%b hf=%b pf=%b ev=%0d, want all 0",
               name, alert, temp_fault, hum_fault, pres_fault, alert_events);
    end
  endtask

  // Pulse reset shortly after a rising edge, check the asynchronous clear.
  task automatic pulse_reset(string name);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(name);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every rising edge after reset the DUT presents a new sample.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (alert !== e.alert || temp_fault !== e.tf || hum_fault !== e.hf ||
          pres_fault !== e.pf || alert_events !== e.ev) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got a=%b t=%b h=%b p=%b ev=%0d, want a=%b t=%b h=%b p=%b ev=%0d",
                 $time, alert, temp_fault, hum_fault, pres_fault, alert_events,
                 e.alert, e.tf, e.hf, e.pf, e.ev);
      end
    end
  end

  function automatic int rnd_temp(bit bad);
    if (!bad) return int'($urandom_range(TMax, TMin));
    return ($urandom_range(1, 0) == 1) ? int'($urandom_range(TMin - 1, 0))
                                       : int'($urandom_range(255, TMax + 1));
  endfunction

  function automatic int rnd_hum(bit bad);
    return bad ? int'($urandom_range(255, HMax + 1)) : int'($urandom_range(HMax, 0));
  endfunction

  function automatic int rnd_pres(bit bad);
    if (!bad) return int'($urandom_range(PMax, PMin));
    return ($urandom_range(1, 0) == 1) ? int'($urandom_range(PMin - 1, 0))
                                       : int'($urandom_range(65535, PMax + 1));
  endfunction

  int bnd_t[8] = '{5, 45, 25, 25, 25, 4, 25, 25};
  int bnd_h[8] = '{50, 50, 85, 50, 50, 50, 86, 50};
  int bnd_p[8] = '{1013, 1013, 1013, 950, 1050, 1013, 1013, 949};

  initial begin
    model_reset();
    // Asynchronous reset with no clock running and a bad sample present.
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_no_clock");
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal hold.
    for (int i = 0; i < 20; i++) cycle(25, 50, 1013);
    // Confirm path, then clear path.
    for (int i = 0; i < 6; i++) cycle(46, 50, 1013);
    for (int i = 0; i < 6; i++) cycle(25, 50, 1013);
    // Glitch rejection: two-cycle pressure burst.
    cycle(25, 50, 1051);
    cycle(25, 50, 1051);
    for (int i = 0; i < 5; i++) cycle(25, 50, 1013);
    // Boundary values, separated by clean cycles so no alert accumulates.
    for (int i = 0; i < 8; i++) begin
      cycle(bnd_t[i], bnd_h[i], bnd_p[i]);
      cycle(25, 50, 1013);
      cycle(25, 50, 1013);
    end
    // Alert, then reset mid-alert.
    for (int i = 0; i < 5; i++) cycle(46, 50, 1013);
    pulse_reset("reset_mid_alert");
    // Reset mid-count: progress must be discarded.
    cycle(0, 50, 1013);
    cycle(0, 50, 1013);
    pulse_reset("reset_mid_count");
    for (int i = 0; i < 4; i++) cycle(0, 50, 1013);
    for (int i = 0; i < 4; i++) cycle(25, 50, 1013);

    // Randomized bursts of faulty and clean samples.
    for (int b = 0; b < 150; b++) begin
      bit bad;
      int len, ch;
      bad = bit'($urandom_range(1, 0));
      len = int'($urandom_range(6, 1));
      for (int i = 0; i < len; i++) begin
        ch = bad ? int'($urandom_range(2, 0)) : 3;
        cycle(rnd_temp(ch == 0), rnd_hum(ch == 1), rnd_pres(ch == 2));
      end
    end

    // Drive enough alert episodes to saturate the event counter.
    for (int k = 0; k < 260; k++) begin
      for (int i = 0; i < 5; i++) cycle(25, 90, 1013);
      for (int i = 0; i < 5; i++) cycle(25, 50, 1013);
    end
    for (int i = 0; i < 5; i++) cycle(25, 50, 2000);
    pulse_reset("reset_saturated");
    for (int i = 0; i < 3; i++) cycle(25, 50, 1013);

    @(posedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
